ps2_rx_buffered: RTL and testbench
==================================

// Module: ps2_rx_buffered
// PURPOSE
//  Parametrised PS/2 device-to-host receiver: synchronises and deglitches ps2c/ps2d, deserialises 11-bit frames,
//  checks odd parity, stop bit and inter-edge timeout, and queues good frames in a first-word-fall-through FIFO.
//  Sits between the PS/2 connector pins and the keyboard/mouse decoder logic; the consumer pops with rd_en.
// PARAMETERS
//  DATA_BITS       8      payload bits per frame (PS/2 = 8), LSB first
//  FILTER_LEN      8      consecutive equal ps2c samples required before the filtered clock changes (>=2)
//  TIMEOUT_CYCLES  20000  clk cycles allowed between ps2c falling edges inside a frame before abort
//  FIFO_AW         2      FIFO address width; depth = 2**FIFO_AW entries
// PORTS
//  clk           in   1            system clock
//  reset         in   1            synchronous, active-low reset
//  ps2d          in   1            PS/2 data pin (async)
//  ps2c          in   1            PS/2 clock pin (async)
//  rx_en         in   1            1 = start bits may open a new frame
//  rd_en         in   1            pop head entry (ignored when empty)
//  clr_overflow  in   1            clears sticky overflow
//  dout          out  DATA_BITS    head-of-FIFO payload (valid when !empty)
//  dout_perr     out  1            head-of-FIFO parity-error flag
//  empty         out  1            FIFO empty
//  full          out  1            FIFO full
//  count         out  FIFO_AW+1    entries held
//  rx_done_tick  out  1            1-cycle pulse: frame with good stop bit completed
//  frame_err     out  1            1-cycle pulse: bad stop bit or timeout, frame discarded
//  overflow      out  1            sticky: completed frame dropped because FIFO full
//  busy          out  1            FSM not in IDLE
// BEHAVIOUR
//  - Reset (reset==0 at clk edge): sync/filter regs = 1, FSM IDLE, FIFO emptied; dout=0, dout_perr=0, empty=1,
//    full=0, count=0, rx_done_tick=0, frame_err=0, overflow=0, busy=0. Reset mid-frame discards the frame.
//  - Inputs: 2-FF synchronisers on ps2c and ps2d. Filtered clock toggles only after FILTER_LEN equal samples.
//  - fall_tick: 1-cycle pulse on filtered clock 1->0; all bit sampling uses synchronised ps2d on fall_tick.
//  - FSM: IDLE -> DATA on fall_tick & rx_en & ps2d==0 (start); fall_tick with ps2d==1 or rx_en==0 ignored.
//    DATA: shift bit in LSB first; after DATA_BITS ticks -> PARITY. PARITY: capture p -> STOP.
//    STOP: ps2d==1 -> push {perr,data}, rx_done_tick, IDLE; ps2d==0 -> frame_err, no push, IDLE.
//  - rx_en only gates the start bit; deasserting it mid-frame lets the frame complete normally.
//  - Parity: odd; perr = ~^{data,p}. Parity-failed frames are still queued with dout_perr=1.
//  - Timeout: counter cleared on every fall_tick and in IDLE; reaching TIMEOUT_CYCLES-1 outside IDLE ->
//    frame_err pulse, frame discarded, IDLE (no push).
//  - Latency: rx_done_tick and push in the cycle after the stop-bit fall_tick; empty falls, dout valid next cycle.
//  - FIFO: push & !full -> store. Pop when rd_en & !empty; head advances next cycle. Simultaneous push+pop when
//    full: both happen, count unchanged, overflow not set. Push when full without pop: frame dropped,
//    rx_done_tick still pulses, overflow=1. clr_overflow & same-cycle overflow event: set wins.
//  - Pointers wrap modulo 2**FIFO_AW; count = wr-rd as FIFO_AW+1 bits; full = count==2**FIFO_AW.
// STRUCTURE
//  - ps2_defs.vh: FSM state encodings (IDLE/DATA/PARITY/STOP), PS2_FRAME_BITS=11, odd-parity constant.
//  - Sub-module ps2_rx_fifo: generic synchronous FWFT FIFO (width DATA_BITS+1, depth 2**FIFO_AW) with
//    count/full/empty; receiver front-end, filter, FSM and timeout stay in ps2_rx_buffered.
// TESTING (clk 20 ns, ps2c half-period 40 clk, FILTER_LEN=4, TIMEOUT_CYCLES=500, FIFO_AW=2)
//  1. Frame start0, data LSB-first 0,0,1,1,1,0,0,0, p=0, stop1 -> one rx_done_tick, dout=0x1C, dout_perr=0, count=1.
//  2. Same data with p=1 -> dout=0x1C, dout_perr=1; rd_en 1 cycle -> empty=1, count=0.
//  3. Frame 0xA5 with stop bit 0 -> frame_err pulse, no rx_done_tick, empty stays 1; then 0x5A received clean.
//  4. Stop ps2c after 4 data bits -> frame_err ~500 clk later, busy=0; following frame 0xAA -> dout=0xAA.
//  5. Send 0x01..0x05 without popping -> full=1 after 4, overflow=1 after 5th; pops yield 0x01..0x04 in order;
//     clr_overflow -> overflow=0.
//  6. 2-cycle low glitch on ps2c in IDLE -> no state change; reset low after 3 data bits -> busy=0, empty=1.

Source files
------------

// File: rtl/ps2_rx_buffered_pkg.sv
// Shared constants for the buffered PS/2 receiver: FSM state encodings,
// PS/2 frame length and the parity sense used on the wire.
package ps2_rx_buffered_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DATA   = 2'd1;
    localparam logic [1:0] ST_PARITY = 2'd2;
    localparam logic [1:0] ST_STOP   = 2'd3;

    localparam int PS2_FRAME_BITS = 11;

    // XOR of payload and parity bit must equal this for a good frame.
    localparam logic ODD_PARITY = 1'b1;

endpackage

// File: rtl/ps2_rx_fifo.sv
// Generic synchronous first-word-fall-through FIFO with occupancy count.
// The head entry is presented on dout whenever the FIFO is not empty.
module ps2_rx_fifo #(
    parameter int WIDTH = 9,
    parameter int AW    = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] din,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full,
    output logic [AW:0]      count
);

    localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

    logic [WIDTH-1:0] mem [2**AW];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             rd_fire;
    logic             wr_fire;

    assign count   = wr_ptr - rd_ptr;
    assign full    = (count == DEPTH);
    assign empty   = (count == '0);
    // A pop frees a slot in the same cycle, so a full FIFO still accepts push+pop.
    assign rd_fire = rd_en && !empty;
    assign wr_fire = wr_en && (!full || rd_fire);
    assign dout    = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_fire) wr_ptr <= wr_ptr + 1'b1;
            if (rd_fire) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_fire) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/ps2_rx_buffered.sv
// PS/2 device-to-host receiver: pin synchronisers, clock deglitch filter,
// frame deserialiser with parity/stop/timeout checks, and an output FIFO.
module ps2_rx_buffered
    import ps2_rx_buffered_pkg::*;
#(
    parameter int DATA_BITS      = 8,
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 20000,
    parameter int FIFO_AW        = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ps2d,
    input  logic                 ps2c,
    input  logic                 rx_en,
    input  logic                 rd_en,
    input  logic                 clr_overflow,
    output logic [DATA_BITS-1:0] dout,
    output logic                 dout_perr,
    output logic                 empty,
    output logic                 full,
    output logic [FIFO_AW:0]     count,
    output logic                 rx_done_tick,
    output logic                 frame_err,
    output logic                 overflow,
    output logic                 busy
);

    localparam int FC_W = $clog2(FILTER_LEN);
    localparam int TO_W = $clog2(TIMEOUT_CYCLES);
    localparam int BC_W = $clog2(DATA_BITS + 1);

    function automatic logic parity_err(input logic [DATA_BITS-1:0] d, input logic p);
        return (^{d, p}) != ODD_PARITY;
    endfunction

    logic                 ps2c_p0, ps2c_p1, ps2d_p0, ps2d_p1;
    logic                 filt_clk;
    logic [FC_W-1:0]      filt_cnt;
    logic                 fall_tick_p2;
    logic [1:0]           state;
    logic [BC_W-1:0]      bit_cnt;
    logic [TO_W-1:0]      to_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bit;
    logic                 push_p3;
    logic [DATA_BITS:0]   fifo_dout;

    // Stage p0/p1: synchronisers; p2: filtered clock and falling-edge tick
    always_ff @(posedge clk) begin
        if (!reset) begin
            ps2c_p0      <= 1'b1;
            ps2c_p1      <= 1'b1;
            ps2d_p0      <= 1'b1;
            ps2d_p1      <= 1'b1;
            filt_clk     <= 1'b1;
            filt_cnt     <= '0;
            fall_tick_p2 <= 1'b0;
        end else begin
            ps2c_p0      <= ps2c;
            ps2c_p1      <= ps2c_p0;
            ps2d_p0      <= ps2d;
            ps2d_p1      <= ps2d_p0;
            fall_tick_p2 <= 1'b0;
            if (ps2c_p1 == filt_clk) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FC_W'(FILTER_LEN - 1)) begin
                filt_clk     <= ps2c_p1;
                filt_cnt     <= '0;
                fall_tick_p2 <= filt_clk;
            end else begin
                filt_cnt <= filt_cnt + 1'b1;
            end
        end
    end

    // Stage p3: frame FSM, timeout and completion pulses
    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= ST_IDLE;
            bit_cnt      <= '0;
            to_cnt       <= '0;
            rx_done_tick <= 1'b0;
            frame_err    <= 1'b0;
            push_p3      <= 1'b0;
        end else begin
            rx_done_tick <= 1'b0;
            frame_err    <= 1'b0;
            push_p3      <= 1'b0;
            to_cnt       <= (state == ST_IDLE || fall_tick_p2) ? '0 : to_cnt + 1'b1;
            case (state)
                ST_IDLE: begin
                    if (fall_tick_p2 && rx_en && !ps2d_p1) begin
                        state   <= ST_DATA;
                        bit_cnt <= '0;
                    end
                end
                ST_DATA: begin
                    if (fall_tick_p2) begin
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == BC_W'(DATA_BITS - 1)) state <= ST_PARITY;
                    end
                end
                ST_PARITY: begin
                    if (fall_tick_p2) state <= ST_STOP;
                end
                default: begin
                    if (fall_tick_p2) begin
                        state        <= ST_IDLE;
                        push_p3      <= ps2d_p1;
                        rx_done_tick <= ps2d_p1;
                        frame_err    <= !ps2d_p1;
                    end
                end
            endcase
            if (state != ST_IDLE && !fall_tick_p2 && to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                state     <= ST_IDLE;
                frame_err <= 1'b1;
            end
        end
    end

    // Payload and parity capture; shreg holds until the next start bit, so the push reads it directly.
    always_ff @(posedge clk) begin
        if (fall_tick_p2 && state == ST_DATA) shreg <= {ps2d_p1, shreg[DATA_BITS-1:1]};
        if (fall_tick_p2 && state == ST_PARITY) par_bit <= ps2d_p1;
    end

    always_ff @(posedge clk) begin
        if (!reset)
            overflow <= 1'b0;
        else if (push_p3 && full && !rd_en)
            overflow <= 1'b1;
        else if (clr_overflow)
            overflow <= 1'b0;
    end

    ps2_rx_fifo #(
        .WIDTH (DATA_BITS + 1),
        .AW    (FIFO_AW)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .wr_en (push_p3),
        .din   ({parity_err(shreg, par_bit), shreg}),
        .rd_en (rd_en),
        .dout  (fifo_dout),
        .empty (empty),
        .full  (full),
        .count (count)
    );

    assign dout      = fifo_dout[DATA_BITS-1:0];
    assign dout_perr = fifo_dout[DATA_BITS];
    assign busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_ps2_rx_buffered.sv
// Scoreboard bench for ps2_rx_buffered: a host-side PS/2 device model drives
// frames, expected events and FIFO contents are queued and checked by monitors.
module tb_ps2_rx_buffered;
    import ps2_rx_buffered_pkg::*;

    localparam int EV_DONE = 1;
    localparam int EV_ERR  = 2;
    localparam int DEPTH   = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       ps2d = 1'b1;
    logic       ps2c = 1'b1;
    logic       rx_en = 1'b0;
    logic       rd_en = 1'b0;
    logic       clr_overflow = 1'b0;
    logic [7:0] dout;
    logic       dout_perr, empty, full, rx_done_tick, frame_err, overflow, busy;
    logic [2:0] count;

    int         errors = 0;
    int         checks = 0;
    int         evt_q[$];
    logic [8:0] mq[$];
    logic       ovf_exp = 1'b0;

    ps2_rx_buffered #(
        .DATA_BITS(8), .FILTER_LEN(4), .TIMEOUT_CYCLES(500), .FIFO_AW(2)
    ) dut (
        .clk(clk), .reset(reset), .ps2d(ps2d), .ps2c(ps2c), .rx_en(rx_en),
        .rd_en(rd_en), .clr_overflow(clr_overflow), .dout(dout), .dout_perr(dout_perr),
        .empty(empty), .full(full), .count(count), .rx_done_tick(rx_done_tick),
        .frame_err(frame_err), .overflow(overflow), .busy(busy)
    );

    always #10 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Device-side frame: data set while ps2c high, 40-clk low and high halves.
    task automatic send_bits(input logic [7:0] d, input logic p, input logic stop, input int nbits);
        logic [10:0] fr;
        fr = {stop, p, d, 1'b0};
        for (int i = 0; i < nbits && i < PS2_FRAME_BITS; i++) begin
            ps2d = fr[i];
            wait_clk(20);
            ps2c = 1'b0;
            wait_clk(40);
            ps2c = 1'b1;
            wait_clk(20);
        end
        ps2d = 1'b1;
    endtask

    // Reference behaviour of a whole frame, expressed as outcomes.
    task automatic send_frame(input logic [7:0] d, input logic p, input logic stop);
        logic perr;
        perr = (($countones(d) + int'(p)) % 2) == 0;
        if (rx_en) begin
            if (stop) begin
                evt_q.push_back(EV_DONE);
                if (mq.size() < DEPTH) mq.push_back({perr, d});
                else ovf_exp = 1'b1;
            end else begin
                evt_q.push_back(EV_ERR);
            end
        end
        send_bits(d, p, stop, PS2_FRAME_BITS);
    endtask

    task automatic wait_events(input string name, input int budget);
        int n = 0;
        while (evt_q.size() > 0 && n < budget) begin
            wait_clk(1);
            n++;
        end
        chk(name, evt_q.size(), 0);
    endtask

    task automatic pop_one();
        wait_clk(1);
        rd_en = 1'b1;
        wait_clk(1);
        rd_en = 1'b0;
    endtask

    task automatic pulse_clr();
        wait_clk(1);
        clr_overflow = 1'b1;
        wait_clk(1);
        clr_overflow = 1'b0;
        ovf_exp = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_dout"}, 32'(dout), 0);
        chk({tag, "_dout_perr"}, 32'(dout_perr), 0);
        chk({tag, "_empty"}, 32'(empty), 1);
        chk({tag, "_full"}, 32'(full), 0);
        chk({tag, "_count"}, 32'(count), 0);
        chk({tag, "_overflow"}, 32'(overflow), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_pulses"}, 32'({rx_done_tick, frame_err}), 0);
    endtask

    // Event monitor: every completion/error pulse must match the next expected outcome.
    always @(negedge clk) begin
        if (reset && (rx_done_tick || frame_err)) begin
            int exp_ev;
            int act_ev;
            act_ev = rx_done_tick ? EV_DONE : EV_ERR;
            if (rx_done_tick && frame_err) act_ev = 3;
            exp_ev = (evt_q.size() > 0) ? evt_q.pop_front() : 0;
            chk("event", act_ev, exp_ev);
        end
    end

    // Read monitor: every accepted pop must deliver the model's head entry.
    always @(negedge clk) begin
        if (reset && rd_en) begin
            if (!empty) begin
                logic [8:0] e;
                e = (mq.size() > 0) ? mq.pop_front() : 9'h1FF;
                chk("pop_data", 32'({dout_perr, dout}), 32'(e));
            end else begin
                chk("pop_on_empty_model_size", mq.size(), 0);
            end
        end
    end

    initial begin
        #(90_000 * 20);
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic glitch_busy;
        wait_clk(3);
        check_reset_state("reset");
        reset = 1'b1;
        rx_en = 1'b1;
        wait_clk(5);

        // Clean frame 0x1C, good parity
        send_frame(8'h1C, 1'b0, 1'b1);
        wait_events("t1_events", 100);
        chk("t1_count", 32'(count), 1);
        chk("t1_dout", 32'(dout), 8'h1C);
        chk("t1_perr", 32'(dout_perr), 0);

        // Same payload, wrong parity: queued with error flag
        send_frame(8'h1C, 1'b1, 1'b1);
        wait_events("t2_events", 100);
        chk("t2_count", 32'(count), 2);
        pop_one();
        chk("t2_head_perr", 32'(dout_perr), 1);
        pop_one();
        chk("t2_empty", 32'(empty), 1);
        chk("t2_count0", 32'(count), 0);

        // Bad stop bit, then a clean frame
        send_frame(8'hA5, 1'b1, 1'b0);
        wait_events("t3_err_events", 100);
        chk("t3_empty", 32'(empty), 1);
        send_frame(8'h5A, 1'b1, 1'b1);
        wait_events("t3_events", 100);
        pop_one();

        // Stalled clock mid-frame: timeout discards, then recovery
        evt_q.push_back(EV_ERR);
        send_bits(8'h0F, 1'b0, 1'b1, 5);
        chk("t4_busy_stalled", 32'(busy), 1);
        wait_events("t4_timeout", 700);
        chk("t4_busy", 32'(busy), 0);
        send_frame(8'hAA, 1'b1, 1'b1);
        wait_events("t4_events", 100);
        chk("t4_dout", 32'(dout), 8'hAA);
        pop_one();

        // Fill, overflow, ordered drain, clear
        for (int i = 1; i <= 5; i++) begin
            send_frame(8'(i), 1'b0, 1'b1);
            wait_events("t5_events", 100);
            if (i == 4) chk("t5_full", 32'(full), 1);
            if (i == 4) chk("t5_ovf_early", 32'(overflow), 0);
        end
        chk("t5_overflow", 32'(overflow), 1);
        chk("t5_count", 32'(count), 4);
        for (int i = 0; i < 4; i++) pop_one();
        chk("t5_empty", 32'(empty), 1);
        chk("t5_ovf_sticky", 32'(overflow), 1);
        pulse_clr();
        chk("t5_ovf_clr", 32'(overflow), 0);

        // Short clock glitch with data low must not open a frame
        ps2d = 1'b0;
        wait_clk(1);
        ps2c = 1'b0;
        wait_clk(2);
        ps2c = 1'b1;
        glitch_busy = 1'b0;
        for (int i = 0; i < 20; i++) begin
            wait_clk(1);
            glitch_busy |= busy;
        end
        ps2d = 1'b1;
        chk("t6_glitch_busy", 32'(glitch_busy), 0);

        // Reset mid-frame with data buffered
        send_frame(8'h33, 1'b1, 1'b1);
        wait_events("t6_events", 100);
        send_bits(8'hC3, 1'b0, 1'b1, 4);
        chk("t6_busy_mid", 32'(busy), 1);
        reset = 1'b0;
        wait_clk(2);
        mq.delete();
        evt_q.delete();
        ovf_exp = 1'b0;
        check_reset_state("t6_reset");
        reset = 1'b1;
        wait_clk(5);

        // Randomised frames against the outcome model
        for (int n = 0; n < 14; n++) begin
            logic [7:0] d;
            int npop;
            d = 8'($urandom);
            rx_en = ($urandom % 6) != 0;
            send_frame(d, 1'($urandom), ($urandom % 5) != 0);
            rx_en = 1'b1;
            wait_events("rnd_events", 100);
            chk("rnd_count", 32'(count), mq.size());
            chk("rnd_overflow", 32'(overflow), 32'(ovf_exp));
            npop = $urandom_range(0, 2);
            for (int k = 0; k < npop; k++) pop_one();
            if (($urandom % 4) == 0) pulse_clr();
        end

        for (int k = 0; k < 2 * DEPTH && !empty; k++) pop_one();
        chk("final_model_empty", mq.size(), 0);
        chk("final_empty", 32'(empty), 1);
        wait_clk(5);
        chk("final_pending_events", evt_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
